// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ local requesters onto one APB completer port.
// Optional ACCESS-phase timeout abort is enabled by defining APB_ARB_TIMEOUT_EN.
module apb_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      pclk,
    input  logic                      preset,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ-1:0]        req_write_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic [NUM_REQ-1:0]        rsp_valid_o,
    output logic [DATA_W-1:0]         rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic                      psel,
    output logic                      penable,
    output logic [ADDR_W-1:0]         paddr,
    output logic                      pwrite,
    output logic [DATA_W-1:0]         pwdata,
    input  logic                      pready,
    input  logic [DATA_W-1:0]         prdata
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [ADDR_W-1:0]  paddr_q, paddr_d;
    logic               pwrite_q, pwrite_d;
    logic [DATA_W-1:0]  pwdata_q, pwdata_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               rsp_pend_q, rsp_pend_d;
    logic               err_q, err_d;

    logic               grant_found;
    logic [IDX_W-1:0]   grant_idx;
    int                 cand;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 5) ? $clog2(TIMEOUT_CYCLES + 1) : 5;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`else
    wire unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    // Search starts one past the last winner, so the last winner has lowest priority.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(ptr_q) + k) % NUM_REQ;
            if (!grant_found && req_valid_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        rdata_d     = rdata_q;
        rsp_pend_d  = 1'b0;
        err_d       = 1'b0;
        req_ready_o = '0;
`ifdef APB_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    req_ready_o[grant_idx] = 1'b1;
                    paddr_d  = req_addr_i[int'(grant_idx)*ADDR_W +: ADDR_W];
                    pwdata_d = req_wdata_i[int'(grant_idx)*DATA_W +: DATA_W];
                    pwrite_d = req_write_i[grant_idx];
                    owner_d  = grant_idx;
                    ptr_d    = grant_idx;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_ACCESS: begin
                if (pready) begin
                    rdata_d    = pwrite_q ? '0 : prdata;
                    rsp_pend_d = 1'b1;
                    state_d    = ST_IDLE;
                end
`ifdef APB_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // This is the TIMEOUT_CYCLES-th stalled ACCESS cycle: give up.
                    rdata_d    = '0;
                    rsp_pend_d = 1'b1;
                    err_d      = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= IDX_W'(NUM_REQ - 1);
            owner_q    <= '0;
            paddr_q    <= '0;
            pwrite_q   <= 1'b0;
            pwdata_q   <= '0;
            rdata_q    <= '0;
            rsp_pend_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            paddr_q    <= paddr_d;
            pwrite_q   <= pwrite_d;
            pwdata_q   <= pwdata_d;
            rdata_q    <= rdata_d;
            rsp_pend_q <= rsp_pend_d;
            err_q      <= err_d;
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
    assign rsp_err_o = rsp_pend_q & err_q;
`else
    assign rsp_err_o = 1'b0;
`endif

    always_comb begin
        rsp_valid_o = '0;
        if (rsp_pend_q) begin
            rsp_valid_o[owner_q] = 1'b1;
        end
    end

    assign rsp_rdata_o = rsp_pend_q ? rdata_q : '0;
    assign psel        = (state_q != ST_IDLE);
    assign penable     = (state_q == ST_ACCESS);
    assign paddr       = paddr_q;
    assign pwrite      = pwrite_q;
    assign pwdata      = pwdata_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: per-cycle vector table plus hand sequences for
// round robin, reset during ACCESS and the stalled-completer case.
module tb_apb_req_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            pclk = 1'b0;
    logic            preset = 1'b1;
    logic [N-1:0]    req_valid_i = '0;
    logic [N-1:0]    req_write_i = '0;
    logic [N*AW-1:0] req_addr_i;
    logic [N*DW-1:0] req_wdata_i;
    logic [N-1:0]    req_ready_o;
    logic [N-1:0]    rsp_valid_o;
    logic [DW-1:0]   rsp_rdata_o;
    logic            rsp_err_o;
    logic            psel;
    logic            penable;
    logic [AW-1:0]   paddr;
    logic            pwrite;
    logic [DW-1:0]   pwdata;
    logic            pready = 1'b0;
    logic [DW-1:0]   prdata = '0;

    int checks = 0;
    int errors = 0;

    apb_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(16)) dut (
        .pclk(pclk), .preset(preset),
        .req_valid_i(req_valid_i), .req_write_i(req_write_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
        .pready(pready), .prdata(prdata)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  write;
        logic        rdy;
        logic [31:0] rdat;
        logic [3:0]  exp_ready;
        logic        exp_psel;
        logic        exp_pen;
        logic [3:0]  exp_rsp;
        logic [31:0] exp_rdata;
        logic [31:0] exp_paddr;
        logic [31:0] exp_pwdata;
        logic        exp_pwrite;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge pclk);
        #1;
    endtask

    task automatic do_reset();
        preset = 1'b1;
        #1;
        next_cycle();
        preset = 1'b0;
    endtask

    initial begin
        int grants;
        int psel_hi;
        int rsp_seen;
        logic [3:0] exp_r;
        logic [3:0] exp_v;

        for (int i = 0; i < N; i++) begin
            req_addr_i[i*AW +: AW]  = 32'h0000_9000 + 32'(i) * 32'h1000;
            req_wdata_i[i*DW +: DW] = 32'h1234_5678 + 32'(i);
        end

        // valid write rdy prdata | ready psel pen rsp rdata paddr pwdata pwrite
        vecs[0]  = '{4'b0010, 4'b0000, 1'b0, 32'h0,        4'b0010, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0,    32'h0,        1'b0};
        vecs[1]  = '{4'b0000, 4'b0000, 1'b0, 32'h0,        4'b0000, 1'b1, 1'b0, 4'b0000, 32'h0,        32'hA000, 32'h1234_5679, 1'b0};
        vecs[2]  = '{4'b0000, 4'b0000, 1'b1, 32'hDEADBEEF, 4'b0000, 1'b1, 1'b1, 4'b0000, 32'h0,        32'hA000, 32'h1234_5679, 1'b0};
        vecs[3]  = '{4'b0000, 4'b0000, 1'b0, 32'h0,        4'b0000, 1'b0, 1'b0, 4'b0010, 32'hDEADBEEF, 32'hA000, 32'h1234_5679, 1'b0};
        vecs[4]  = '{4'b0001, 4'b0001, 1'b0, 32'h0,        4'b0001, 1'b0, 1'b0, 4'b0000, 32'h0,        32'hA000, 32'h1234_5679, 1'b0};
        vecs[5]  = '{4'b0000, 4'b0000, 1'b0, 32'h0,        4'b0000, 1'b1, 1'b0, 4'b0000, 32'h0,        32'h9000, 32'h1234_5678, 1'b1};
        vecs[6]  = '{4'b0000, 4'b0000, 1'b0, 32'h0,        4'b0000, 1'b1, 1'b1, 4'b0000, 32'h0,        32'h9000, 32'h1234_5678, 1'b1};
        vecs[7]  = '{4'b0000, 4'b0000, 1'b0, 32'h0,        4'b0000, 1'b1, 1'b1, 4'b0000, 32'h0,        32'h9000, 32'h1234_5678, 1'b1};
        vecs[8]  = '{4'b0000, 4'b0000, 1'b0, 32'h0,        4'b0000, 1'b1, 1'b1, 4'b0000, 32'h0,        32'h9000, 32'h1234_5678, 1'b1};
        vecs[9]  = '{4'b0000, 4'b0000, 1'b1, 32'hFFFFFFFF, 4'b0000, 1'b1, 1'b1, 4'b0000, 32'h0,        32'h9000, 32'h1234_5678, 1'b1};
        vecs[10] = '{4'b0000, 4'b0000, 1'b0, 32'h0,        4'b0000, 1'b0, 1'b0, 4'b0001, 32'h0,        32'h9000, 32'h1234_5678, 1'b1};
        vecs[11] = '{4'b1000, 4'b1000, 1'b0, 32'h0,        4'b1000, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h9000, 32'h1234_5678, 1'b1};
        vecs[12] = '{4'b0100, 4'b0000, 1'b0, 32'h0,        4'b0000, 1'b1, 1'b0, 4'b0000, 32'h0,        32'hC000, 32'h1234_567B, 1'b1};
        vecs[13] = '{4'b0000, 4'b0000, 1'b1, 32'h5555AAAA, 4'b0000, 1'b1, 1'b1, 4'b0000, 32'h0,        32'hC000, 32'h1234_567B, 1'b1};
        vecs[14] = '{4'b0000, 4'b0000, 1'b0, 32'h0,        4'b0000, 1'b0, 1'b0, 4'b1000, 32'h0,        32'hC000, 32'h1234_567B, 1'b1};
        vecs[15] = '{4'b0000, 4'b0000, 1'b0, 32'h0,        4'b0000, 1'b0, 1'b0, 4'b0000, 32'h0,        32'hC000, 32'h1234_567B, 1'b1};

        // Reset state, checked while reset is still asserted.
        #2;
        chk("reset_psel", 64'(psel), 64'(0));
        chk("reset_penable", 64'(penable), 64'(0));
        chk("reset_rsp_valid", 64'(rsp_valid_o), 64'(0));
        chk("reset_ready", 64'(req_ready_o), 64'(0));
        chk("reset_paddr", 64'(paddr), 64'(0));
        next_cycle();
        next_cycle();
        preset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            req_valid_i = vecs[i].valid;
            req_write_i = vecs[i].write;
            pready      = vecs[i].rdy;
            prdata      = vecs[i].rdat;
            @(negedge pclk);
            chk($sformatf("v%0d_ready", i), 64'(req_ready_o), 64'(vecs[i].exp_ready));
            chk($sformatf("v%0d_psel", i), 64'(psel), 64'(vecs[i].exp_psel));
            chk($sformatf("v%0d_penable", i), 64'(penable), 64'(vecs[i].exp_pen));
            chk($sformatf("v%0d_rsp_valid", i), 64'(rsp_valid_o), 64'(vecs[i].exp_rsp));
            chk($sformatf("v%0d_paddr", i), 64'(paddr), 64'(vecs[i].exp_paddr));
            chk($sformatf("v%0d_pwdata", i), 64'(pwdata), 64'(vecs[i].exp_pwdata));
            chk($sformatf("v%0d_pwrite", i), 64'(pwrite), 64'(vecs[i].exp_pwrite));
            chk($sformatf("v%0d_err", i), 64'(rsp_err_o), 64'(0));
            if (vecs[i].exp_rsp != 4'b0000)
                chk($sformatf("v%0d_rdata", i), 64'(rsp_rdata_o), 64'(vecs[i].exp_rdata));
            $display("vec %0d: valid=%b ready=%b psel=%b penable=%b rsp=%b rdata=%h",
                     i, req_valid_i, req_ready_o, psel, penable, rsp_valid_o, rsp_rdata_o);
            next_cycle();
        end

        // Round robin with all requesters valid and zero wait states: grant every 3rd cycle.
        req_valid_i = '0;
        pready      = 1'b0;
        do_reset();
        req_valid_i = 4'b1111;
        req_write_i = 4'b0000;
        pready      = 1'b1;
        prdata      = 32'h0000_0042;
        grants      = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge pclk);
            exp_r = (c % 3 == 0) ? 4'(1 << ((c / 3) % 4)) : 4'b0000;
            exp_v = (c % 3 == 0 && c > 0) ? 4'(1 << (((c / 3) - 1) % 4)) : 4'b0000;
            chk($sformatf("rr_c%0d_ready", c), 64'(req_ready_o), 64'(exp_r));
            chk($sformatf("rr_c%0d_rsp", c), 64'(rsp_valid_o), 64'(exp_v));
            if (req_ready_o != 0) grants++;
            $display("rr cycle %0d: ready=%b rsp=%b", c, req_ready_o, rsp_valid_o);
            next_cycle();
        end
        chk("rr_grant_count", 64'(grants), 64'(5));

        // Reset asserted during ACCESS.
        req_valid_i = '0;
        pready      = 1'b0;
        do_reset();
        req_valid_i = 4'b0100;
        @(negedge pclk);
        chk("rst_mid_grant", 64'(req_ready_o), 64'(4'b0100));
        next_cycle();
        req_valid_i = '0;
        next_cycle();
        @(negedge pclk);
        chk("rst_mid_in_access", 64'(penable), 64'(1));
        next_cycle();
        preset = 1'b1;
        #1;
        chk("rst_mid_psel", 64'(psel), 64'(0));
        chk("rst_mid_penable", 64'(penable), 64'(0));
        next_cycle();
        preset = 1'b0;
        pready = 1'b1;
        rsp_seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge pclk);
            if (rsp_valid_o != 0) rsp_seen++;
            next_cycle();
        end
        chk("rst_mid_no_rsp", 64'(rsp_seen), 64'(0));
        req_valid_i = 4'b1111;
        @(negedge pclk);
        chk("rst_mid_first_grant", 64'(req_ready_o), 64'(4'b0001));
        $display("reset mid-access: first grant after release=%b", req_ready_o);
        next_cycle();
        req_valid_i = '0;
        for (int c = 0; c < 3; c++) next_cycle();

        // Completer never ready.
        pready = 1'b0;
        do_reset();
        req_valid_i = 4'b1000;
        @(negedge pclk);
        chk("stall_grant", 64'(req_ready_o), 64'(4'b1000));
        next_cycle();
        req_valid_i = '0;
        psel_hi  = 0;
        rsp_seen = 0;
`ifdef APB_ARB_TIMEOUT_EN
        // SETUP, then 16 stalled ACCESS cycles, then the error response.
        for (int c = 0; c < 17; c++) begin
            @(negedge pclk);
            if (psel) psel_hi++;
            if (rsp_valid_o != 0) rsp_seen++;
            next_cycle();
        end
        chk("timeout_busy_cycles", 64'(psel_hi), 64'(17));
        chk("timeout_no_early_rsp", 64'(rsp_seen), 64'(0));
        @(negedge pclk);
        chk("timeout_rsp", 64'(rsp_valid_o), 64'(4'b1000));
        chk("timeout_err", 64'(rsp_err_o), 64'(1));
        chk("timeout_rdata", 64'(rsp_rdata_o), 64'(0));
        chk("timeout_psel", 64'(psel), 64'(0));
        $display("timeout: rsp=%b err=%b", rsp_valid_o, rsp_err_o);
`else
        for (int c = 0; c < 120; c++) begin
            @(negedge pclk);
            if (psel) psel_hi++;
            if (rsp_valid_o != 0) rsp_seen++;
            next_cycle();
        end
        chk("stall_psel_held", 64'(psel_hi), 64'(120));
        chk("stall_no_rsp", 64'(rsp_seen), 64'(0));
        chk("stall_err", 64'(rsp_err_o), 64'(0));
        $display("stall: psel high for %0d cycles", psel_hi);
        pready = 1'b1;
        prdata = 32'hCAFE_F00D;
        next_cycle();
        pready = 1'b0;
        @(negedge pclk);
        chk("stall_release_rsp", 64'(rsp_valid_o), 64'(4'b1000));
        chk("stall_release_rdata", 64'(rsp_rdata_o), 64'(32'hCAFE_F00D));
        $display("stall release: rsp=%b rdata=%h", rsp_valid_o, rsp_rdata_o);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
